// File: rtl/wave_gen_osc.sv
// Sample-rate oscillator voice: phase accumulator, pulse/saw/triangle shapes, linear envelope.
// Optional noise source (16-bit Galois LFSR on mode 3) enabled by defining WAVE_GEN_OSC_NOISE_EN.
module wave_gen_osc #(
    parameter int ACC_W = 24,
    parameter int IDX_W = 6,
    parameter int OUT_W = 16,
    parameter int AMP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic [ACC_W-1:0]        tune_word,
    input  logic [1:0]              mode,
    input  logic [IDX_W-1:0]        duty,
    input  logic                    gate,
    input  logic [AMP_W-1:0]        amp,
    output logic signed [OUT_W-1:0] music_o,
    output logic                    music_valid
);

    localparam int S = OUT_W - IDX_W;
    localparam logic signed [OUT_W-1:0] P_FS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] N_FS = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

    logic [ACC_W-1:0]        r_phase;
    logic [AMP_W-1:0]        r_env;
    logic                    r_gateQ;
    logic [1:0]              r_mode1;
    logic [IDX_W-1:0]        r_duty1;
    logic                    r_v1;

    logic signed [OUT_W-1:0] r_raw;
    logic [AMP_W-1:0]        r_env2;
    logic                    r_v2;

    logic [AMP_W-1:0]        w_envNext;
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W-1:0]        w_t;
    logic signed [OUT_W-1:0] w_saw;
    logic signed [OUT_W-1:0] w_tri;
    logic signed [OUT_W-1:0] w_noise;
    logic signed [OUT_W-1:0] w_raw;
    logic signed [OUT_W+AMP_W-1:0] w_prod;

    always_comb begin
        w_envNext = r_env;
        if (gate) begin
            if (r_env < amp) begin
                w_envNext = r_env + 1'b1;
            end else if (r_env > amp) begin
                w_envNext = r_env - 1'b1;
            end
        end else if (r_env != '0) begin
            w_envNext = r_env - 1'b1;
        end
    end

    // Stage 1: a gate rising edge at a strobe restarts the phase instead of advancing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_env   <= '0;
            r_gateQ <= 1'b0;
            r_mode1 <= '0;
            r_duty1 <= '0;
            r_v1    <= 1'b0;
        end else begin
            r_v1 <= sample_en;
            if (sample_en) begin
                r_phase <= (gate && !r_gateQ) ? '0 : r_phase + tune_word;
                r_gateQ <= gate;
                r_env   <= w_envNext;
                r_mode1 <= mode;
                r_duty1 <= duty;
            end
        end
    end

`ifdef WAVE_GEN_OSC_NOISE_EN
    logic [15:0]       r_lfsr;
    logic [15:0]       w_lfsrNext;
    logic [OUT_W+15:0] w_noiseWide;

    assign w_lfsrNext  = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
    assign w_noiseWide = {r_lfsr, {OUT_W{1'b0}}};
    assign w_noise     = OUT_W'(w_noiseWide >> 16);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (sample_en) begin
            r_lfsr <= w_lfsrNext;
        end
    end
`else
    assign w_noise = '0;
`endif

    // (x - H) << S is just x with its MSB inverted, left-aligned into the sample word.
    assign w_idx = r_phase[ACC_W-1 -: IDX_W];
    assign w_t   = w_idx[IDX_W-1] ? {~w_idx[IDX_W-2:0], 1'b0} : {w_idx[IDX_W-2:0], 1'b0};
    assign w_saw = {~w_idx[IDX_W-1], w_idx[IDX_W-2:0], {S{1'b0}}};
    assign w_tri = {~w_t[IDX_W-1], w_t[IDX_W-2:0], {S{1'b0}}};

    always_comb begin
        w_raw = '0;
        case (r_mode1)
            2'd0:    w_raw = (w_idx < r_duty1) ? P_FS : N_FS;
            2'd1:    w_raw = w_saw;
            2'd2:    w_raw = w_tri;
            default: w_raw = w_noise;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw  <= '0;
            r_env2 <= '0;
            r_v2   <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_raw  <= w_raw;
                r_env2 <= r_env;
            end
        end
    end

    assign w_prod = $signed({{AMP_W{r_raw[OUT_W-1]}}, r_raw}) * $signed({{OUT_W{1'b0}}, r_env2});

    // Stage 3: the arithmetic shift floors the scaled sample; magnitude always fits OUT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            music_o     <= '0;
            music_valid <= 1'b0;
        end else begin
            music_valid <= r_v2;
            if (r_v2) begin
                music_o <= OUT_W'(w_prod >>> AMP_W);
            end
        end
    end

endmodule
